// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit, one bit per clock.
// Also generates a line break of BREAK_LEN low cycles followed by a recovery cycle.
module uart_tx #(
  parameter int unsigned BREAK_LEN = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  input  logic       brk,
  output logic       ready,
  output logic       signal,
  output logic       done
);

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic [7:0] BRK_LAST = 8'(BREAK_LEN - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] brk_cnt;
  logic [7:0] shift;

  assign ready = (state == IDLE) || (state == STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RECOVER;
      signal  <= 1'b1;
      done    <= 1'b0;
      bit_cnt <= 3'd0;
      brk_cnt <= 8'd0;
      shift   <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        RECOVER: begin
          state  <= IDLE;
          signal <= 1'b1;
        end
        IDLE, STOP: begin
          // brk wins; a simultaneous send stays pending at the source
          if (brk) begin
            state   <= BREAK;
            signal  <= 1'b0;
            brk_cnt <= 8'd0;
          end else if (send) begin
            state  <= START;
            signal <= 1'b0;
            shift  <= data;
          end else begin
            state  <= IDLE;
            signal <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          signal  <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= 3'd0;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            state  <= STOP;
            signal <= 1'b1;
            done   <= 1'b1;
          end else begin
            signal  <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        BREAK: begin
          if (brk_cnt == BRK_LAST) begin
            state  <= RECOVER;
            signal <= 1'b1;
          end else begin
            brk_cnt <= brk_cnt + 8'd1;
          end
        end
        default: begin
          state  <= RECOVER;
          signal <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the one-bit-per-clock UART line format used by the team's frame checker.
- Takes a parallel byte through a valid/ready handshake and drives a frame onto the line:
  - start bit (0),
  - 8 data bits, LSB first,
  - stop bit (1).
- Can also generate a line break (line held low) that forces the far-end checker into its break state.
- Sits on the transmit side of the link. Its `signal` output connects directly to the checker's `signal` input.

Parameters:
- BREAK_LEN, 12, number of cycles the line is held low for a break request; legal range 11..255.

Ports:
- clk     input   1  system clock; all state changes on rising edge
- reset   input   1  synchronous, active-high reset
- data    input   8  byte to transmit; sampled only on acceptance
- send    input   1  request to transmit `data`
- brk     input   1  request to generate a line break
- ready   output  1  transmitter can accept a request this cycle
- signal  output  1  serial line, registered, idle high
- done    output  1  one-cycle pulse, high during the stop-bit cycle of each completed frame

Behaviour:
- Reset (sampled at a rising edge with reset=1):
  - state <= RECOVER, signal <= 1, done <= 0.
  - bit counter, break counter and shift register <= 0.
- States:
  - RECOVER: signal=1, ready=0; next state IDLE unconditionally.
  - IDLE: signal=1, ready=1.
  - START: signal=0.
  - DATA: signal=shift[0]; 8 cycles via a 3-bit counter 0..7; shift right each cycle.
  - STOP: signal=1, done=1, ready=1.
  - BREAK: signal=0 for BREAK_LEN cycles via a counter; next state RECOVER.
- Ready:
  - ready = (state==IDLE || state==STOP).
  - It is a pure decode of the state register, with no combinational path from inputs.
- Acceptance and priority:
  - A request is taken at an edge only when ready=1.
  - brk=1: take brk, go to BREAK. brk has priority.
  - brk=0 and send=1: send is accepted; shift <= data; go to START.
  - send=1 together with brk=1: send is NOT accepted. The source must hold send until a later accepted edge.
  - Neither request in IDLE: stay in IDLE.
  - Neither request in STOP: go to IDLE.
- Latency:
  - Accept at edge t gives signal=0 (start bit) during cycle t+1.
  - Data bits 0..7 follow in cycles t+2..t+9; stop bit in cycle t+10.
- Back-to-back frames:
  - Accepting in STOP puts the next start bit directly after the stop bit.
  - Sustained frame period is 10 cycles with no idle gap.
- Data sampling:
  - data is captured only at acceptance.
  - Changes to data, send or brk while ready=0 are ignored.
- done:
  - Registered, high exactly during the STOP cycle.
  - Never asserted for a break or for an aborted frame.
- Break:
  - Line is low for exactly BREAK_LEN consecutive cycles.
  - Then 1 high cycle in RECOVER (ready=0), then IDLE.
  - Any in-progress frame cannot be broken; brk is only sampled when ready=1.
- Reset mid-frame or mid-break:
  - Abort immediately; signal=1 from the next cycle, done=0.
  - Go through RECOVER before ready rises.
- Illegal or unused state encodings: go to RECOVER with signal=1.
- Line guarantees: the line is never low for more than 9 consecutive cycles outside BREAK. This keeps a break distinguishable from frame data.

Test Plan:
- Reset then idle:
  - Assert reset 2 cycles, release.
  - signal=1 throughout; ready=0 in the first cycle after release, 1 from the second; done=0.
- Single frame:
  - Accept data=0xA5.
  - signal over cycles t+1..t+10 = 0,1,0,1,0,0,1,0,1,1.
  - done=1 only at t+10; ready=1 at t+10 then stays 1 in IDLE.
- Back-to-back frames:
  - Send 0x00, hold send with 0xFF accepted at STOP.
  - Line = 0,0x8,1 then 0,1x8,1 with no idle cycle between frames.
  - Exactly two done pulses, 10 cycles apart.
- Break with simultaneous send:
  - In IDLE, brk=1 and send=1 with data=0x3C (BREAK_LEN=12).
  - signal=0 for exactly 12 cycles, then 1; ready=0 for 13 cycles.
  - Send still held is then accepted and 0x3C transmitted.
  - No done pulse during the break.
- Reset mid-frame:
  - Assert reset during data bit 4 of 0x0F.
  - signal=1 the next cycle; no done pulse; ready returns after the RECOVER cycle.
- Loopback to the frame checker:
  - Drive bytes 0x55, 0xAA, 0x81 back-to-back, then a break, then 0x7E.
  - Checker valid pulses once per frame (4 total).
  - Checker enters its break state during the break and recovers for the 0x7E frame.
